mem_stage_pipe: RTL and testbench
=================================

Name: mem_stage_pipe

Overview:
- Registered, parametrised memory stage of the RISC pipeline, sitting between EX and WB.
- Resolves branch/jump redirects.
- Performs data-memory load/store through a valid/ready request channel plus a response channel.
- Stalls the upstream stage while a memory access is outstanding and delivers one registered writeback pulse per accepted instruction.

Parameters:
- DATA_W, 32, datapath/ALU/memory word width
- ADDR_W, 32, PC and data-memory address width (ADDR_W <= DATA_W; address = low ADDR_W bits of alu_out)
- REG_AW, 4, register-file index width
- ZERO_REG_EN, 1, when 1 writes to register 0 are suppressed
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  stage clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX result valid
- in_ready  out  1  stage can accept (combinational: state==IDLE)
- alu_out  in  DATA_W  ALU result / memory address / jump target
- store_data  in  DATA_W  store write data
- pc_target  in  ADDR_W  precomputed branch target
- dest_reg  in  REG_AW  destination register
- reg_write, mem_to_reg, mem_read, mem_write, branch, jump, zero  in  1 each  control bits from EX
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  ADDR_W  request address
- dmem_wdata  out  DATA_W  store data
- dmem_rsp_valid  in  1  load data valid
- dmem_rdata  in  DATA_W  load data
- redirect_valid  out  1  one-cycle pulse: take PC redirect
- redirect_pc  out  ADDR_W  redirect target
- wb_valid  out  1  one-cycle writeback pulse
- wb_reg_write  out  1  writeback enable
- wb_dest  out  REG_AW  writeback register
- wb_data  out  DATA_W  writeback data
- stall_cnt  out  CNT_W  saturating count of cycles in REQ or WAIT

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE.
  - All registered outputs are 0: dmem_*, redirect_*, wb_*, stall_cnt.
  - in_ready is 1 because it follows state.
  - Any in-flight request is abandoned; a late dmem_rsp_valid after reset is ignored.
- Accept: in_valid & in_ready. All inputs are latched on the accepting edge.
- Redirect:
  - redirect_valid = branch & (jump | zero), registered; it pulses exactly 1 cycle after accept for every instruction class.
  - redirect_pc = jump ? alu_out[ADDR_W-1:0] : pc_target.
  - redirect_valid and redirect_pc are 0 in all other cycles.
- Effective write enable: reg_write & !(ZERO_REG_EN & dest_reg==0).
- Non-memory op (mem_read=0, mem_write=0):
  - wb_valid=1 the cycle after accept, with wb_data=alu_out and the effective write enable.
  - State stays IDLE; back-to-back accepts give one wb pulse per cycle.
- Memory op: mem_write=1 is a store; otherwise mem_read=1 is a load. If both are 1, the store wins.
- State machine IDLE -> REQ on accepting a memory op. REQ behaviour:
  - dmem_req_valid=1; dmem_addr, dmem_we and dmem_wdata are held stable until dmem_req_ready.
  - Store handshake: next state IDLE; wb_valid next cycle with wb_data=alu_out.
  - Load handshake: dmem_req_valid drops next cycle; next state WAIT.
- WAIT: on dmem_rsp_valid, capture data and go IDLE; wb_valid next cycle with wb_data = mem_to_reg ? dmem_rdata : alu_out.
- dmem_rsp_valid in IDLE or REQ is ignored. dmem_req_ready outside REQ is ignored.
- Latency from accept to wb_valid:
  - ALU op: 1 cycle.
  - Store: 1 + request-wait cycles + 1.
  - Load: request handshake + response + 1.
  - Minimum load latency with zero-wait memory is 3 cycles.
- A wb_valid pulse and a new accept may occur in the same cycle.
- stall_cnt increments each cycle state is REQ or WAIT, saturates at all-ones and never wraps.

Test Plan:
- Reset mid-load: accept load, assert dmem_req_ready, drop rst_n while in WAIT, then fire dmem_rsp_valid after reset -> state IDLE, in_ready=1, all outputs 0, no wb_valid.
- ALU stream: 3 back-to-back accepts with alu_out=5,6,7 and dest=3, reg_write=1 -> wb_valid on 3 consecutive cycles with wb_data 5,6,7; in_ready stays 1.
- Branch resolution:
  - branch=1, zero=1, pc_target=0x40 -> redirect pulse, pc=0x40.
  - branch=1, zero=0 -> no pulse.
  - branch=1, jump=1, alu_out=0x100 -> pulse, pc=0x100.
- Store with 2-cycle ready delay: alu_out=0x20, store_data=0xDEADBEEF -> req_valid held 3 cycles with stable addr/wdata, we=1; in_ready=0 throughout; wb_valid the cycle after handshake; stall_cnt=3.
- Load: alu_out=0x10, mem_to_reg=1, dest=0 with ZERO_REG_EN=1, rsp 2 cycles after handshake with rdata=0x1234 -> wb_data=0x1234, wb_reg_write=0; repeat with dest=2 -> wb_reg_write=1.
- Counter saturation, CNT_W=2: hold dmem_req_ready low for 6 cycles -> stall_cnt reaches 3 and stays at 3.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// Memory stage between EX and WB: resolves redirects, issues data-memory load/store, emits one registered writeback per instruction.
// Latency: ALU 1, store 2+req wait, load 3+req/rsp wait; in_ready drops while a memory access is in REQ or WAIT.
module mem_stage_pipe #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_AW      = 4,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] store_data,
    input  logic [ADDR_W-1:0] pc_target,
    input  logic [REG_AW-1:0] dest_reg,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              branch,
    input  logic              jump,
    input  logic              zero,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t state, nextState;

    logic              accept;
    logic              isMem;
    logic              takeBranch;
    logic              effWe;
    logic              reqDone;
    logic              rspDone;

    logic [DATA_W-1:0] lAlu;
    logic [REG_AW-1:0] lDest;
    logic              lWe;
    logic              lMemToReg;
    logic              lStore;

    assign in_ready   = (state == S_IDLE);
    assign accept     = in_valid & in_ready;
    assign isMem      = mem_read | mem_write;
    assign takeBranch = branch & (jump | zero);
    assign effWe      = reg_write & ~((ZERO_REG_EN != 0) && (dest_reg == '0));
    assign reqDone    = (state == S_REQ) & dmem_req_ready;
    assign rspDone    = (state == S_WAIT) & dmem_rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE: if (accept && isMem) nextState = S_REQ;
            S_REQ:  if (dmem_req_ready) nextState = lStore ? S_IDLE : S_WAIT;
            S_WAIT: if (dmem_rsp_valid) nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    // Instruction context held for the duration of a memory access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lAlu      <= '0;
            lDest     <= '0;
            lWe       <= 1'b0;
            lMemToReg <= 1'b0;
            lStore    <= 1'b0;
        end else if (accept) begin
            lAlu      <= alu_out;
            lDest     <= dest_reg;
            lWe       <= effWe;
            lMemToReg <= mem_to_reg;
            lStore    <= mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & takeBranch;
            redirect_pc    <= (accept & takeBranch) ? (jump ? alu_out[ADDR_W-1:0] : pc_target) : '0;
        end
    end

    // Request fields stay frozen from accept until the handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_valid <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
        end else if (accept && isMem) begin
            dmem_req_valid <= 1'b1;
            dmem_we        <= mem_write;
            dmem_addr      <= alu_out[ADDR_W-1:0];
            dmem_wdata     <= store_data;
        end else if (reqDone) begin
            dmem_req_valid <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_dest      <= '0;
            wb_data      <= '0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_dest      <= '0;
            wb_data      <= '0;
            if (accept && !isMem) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= effWe;
                wb_dest      <= dest_reg;
                wb_data      <= alu_out;
            end else if (reqDone && lStore) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= lWe;
                wb_dest      <= lDest;
                wb_data      <= lAlu;
            end else if (rspDone) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= lWe;
                wb_dest      <= lDest;
                wb_data      <= lMemToReg ? dmem_rdata : lAlu;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state != S_IDLE) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboarded bench for mem_stage_pipe: directed ALU/branch/store/load vectors, reset mid-load, stall-counter saturation.
module tb_mem_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] alu_out = '0;
    logic [31:0] store_data = '0;
    logic [31:0] pc_target = '0;
    logic [3:0]  dest_reg = '0;
    logic        reg_write = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    logic        in_ready, dmem_req_valid, dmem_we, redirect_valid, wb_valid, wb_reg_write;
    logic [31:0] dmem_addr, dmem_wdata, redirect_pc, wb_data;
    logic [3:0]  wb_dest;
    logic [15:0] stall_cnt;

    logic        in_ready2, dmem_req_valid2, dmem_we2, redirect_valid2, wb_valid2, wb_reg_write2;
    logic [31:0] dmem_addr2, dmem_wdata2, redirect_pc2, wb_data2;
    logic [3:0]  wb_dest2;
    logic [1:0]  stall_cnt2;

    typedef struct packed {
        logic        we;
        logic [3:0]  dest;
        logic [31:0] data;
        logic [31:0] due;
    } wbE_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] due;
    } rdE_t;

    wbE_t wbQ[$];
    rdE_t rdQ[$];
    int   nCmp = 0;
    int   nFail = 0;
    int   cyc = 0;
    int   expStall = 0;

    mem_stage_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .store_data(store_data), .pc_target(pc_target), .dest_reg(dest_reg),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .zero(zero),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata(dmem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
        .stall_cnt(stall_cnt)
    );

    mem_stage_pipe #(.CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .alu_out(alu_out), .store_data(store_data), .pc_target(pc_target), .dest_reg(dest_reg),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .zero(zero),
        .dmem_req_valid(dmem_req_valid2), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we2),
        .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata(dmem_rdata), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .wb_valid(wb_valid2), .wb_reg_write(wb_reg_write2), .wb_dest(wb_dest2), .wb_data(wb_data2),
        .stall_cnt(stall_cnt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int satf(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Pops the expected queues whenever the DUT presents a writeback or redirect.
    task automatic monitor();
        wbE_t wa, we;
        rdE_t ra, re;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                wa = '{wb_reg_write, wb_dest, wb_data, cyc};
                nCmp++;
                if (wbQ.size() == 0) begin
                    nFail++;
                    $display("FAIL wb_unexpected: got we=%0b dest=%0d data=0x%0h at cycle %0d, none expected",
                             wa.we, wa.dest, wa.data, cyc);
                end else begin
                    we = wbQ.pop_front();
                    if (wa !== we) begin
                        nFail++;
                        $display("FAIL wb: got we=%0b dest=%0d data=0x%0h cyc=%0d expected we=%0b dest=%0d data=0x%0h cyc=%0d",
                                 wa.we, wa.dest, wa.data, wa.due, we.we, we.dest, we.data, we.due);
                    end
                end
            end
            if (redirect_valid) begin
                ra = '{redirect_pc, cyc};
                nCmp++;
                if (rdQ.size() == 0) begin
                    nFail++;
                    $display("FAIL redirect_unexpected: got pc=0x%0h at cycle %0d, none expected", ra.pc, cyc);
                end else begin
                    re = rdQ.pop_front();
                    if (ra !== re) begin
                        nFail++;
                        $display("FAIL redirect: got pc=0x%0h cyc=%0d expected pc=0x%0h cyc=%0d",
                                 ra.pc, ra.due, re.pc, re.due);
                    end
                end
            end
        end
    endtask

    task automatic clearIn();
        in_valid = 0; alu_out = '0; store_data = '0; pc_target = '0; dest_reg = '0;
        reg_write = 0; mem_to_reg = 0; mem_read = 0; mem_write = 0;
        branch = 0; jump = 0; zero = 0;
    endtask

    // Called at a negedge; leaves in_valid high so calls chain back-to-back.
    task automatic sendOp(input logic [31:0] alu, input logic [31:0] pct, input logic [3:0] dest,
                          input logic rw, input logic br, input logic jp, input logic zr,
                          input logic expWe, input logic expRedir, input logic [31:0] expPc);
        in_valid = 1; alu_out = alu; pc_target = pct; dest_reg = dest; reg_write = rw;
        branch = br; jump = jp; zero = zr; mem_read = 0; mem_write = 0; mem_to_reg = 0;
        chk("alu_in_ready", in_ready, 1);
        wbQ.push_back('{expWe, dest, alu, cyc + 1});
        if (expRedir) rdQ.push_back('{expPc, cyc + 1});
        @(negedge clk);
    endtask

    task automatic doStore(input logic [31:0] alu, input logic [31:0] data, input logic mr, input int waitN);
        clearIn();
        in_valid = 1; alu_out = alu; store_data = data; mem_write = 1; mem_read = mr;
        chk("st_in_ready_idle", in_ready, 1);
        @(negedge clk);
        clearIn();
        for (int i = 0; i <= waitN; i++) begin
            chk("st_req_valid", dmem_req_valid, 1);
            chk("st_we", dmem_we, 1);
            chk("st_addr", dmem_addr, alu);
            chk("st_wdata", dmem_wdata, data);
            chk("st_in_ready_busy", in_ready, 0);
            chk("st_stall_cnt", stall_cnt, expStall + i);
            if (i == waitN) begin
                dmem_req_ready = 1; dmem_rsp_valid = 0;
                wbQ.push_back('{1'b0, 4'd0, alu, cyc + 1});
            end else begin
                dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rdata = 32'hFFFF_0000;
            end
            @(negedge clk);
        end
        dmem_req_ready = 0; dmem_rsp_valid = 0;
        expStall += waitN + 1;
        chk("st_req_drop", dmem_req_valid, 0);
        chk("st_in_ready_done", in_ready, 1);
        chk("st_stall_final", stall_cnt, expStall);
    endtask

    task automatic doLoad(input logic [31:0] alu, input logic [3:0] dest, input logic m2r,
                          input logic [31:0] rdata, input int reqWait, input int rspWait,
                          input logic expWe, input logic [31:0] expData);
        clearIn();
        in_valid = 1; alu_out = alu; store_data = 32'h0BAD_0BAD; dest_reg = dest;
        reg_write = 1; mem_read = 1; mem_to_reg = m2r;
        chk("ld_in_ready_idle", in_ready, 1);
        @(negedge clk);
        clearIn();
        for (int i = 0; i <= reqWait; i++) begin
            chk("ld_req_valid", dmem_req_valid, 1);
            chk("ld_we", dmem_we, 0);
            chk("ld_addr", dmem_addr, alu);
            chk("ld_in_ready_busy", in_ready, 0);
            chk("ld_stall_cnt", stall_cnt, expStall + i);
            chk("ld_stall_sat", stall_cnt2, satf(expStall + i));
            if (i == reqWait) begin
                dmem_req_ready = 1; dmem_rsp_valid = 0;
            end else begin
                dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rdata = 32'hFFFF_FFFF;
            end
            @(negedge clk);
        end
        for (int j = 0; j <= rspWait; j++) begin
            chk("ld_req_dropped", dmem_req_valid, 0);
            chk("ld_in_ready_wait", in_ready, 0);
            chk("ld_stall_wait", stall_cnt, expStall + reqWait + 1 + j);
            if (j == rspWait) begin
                dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rdata = rdata;
                wbQ.push_back('{expWe, dest, expData, cyc + 1});
            end else begin
                dmem_req_ready = 1; dmem_rsp_valid = 0;
            end
            @(negedge clk);
        end
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = '0;
        expStall += reqWait + 1 + rspWait + 1;
        chk("ld_in_ready_done", in_ready, 1);
        chk("ld_stall_final", stall_cnt, expStall);
        chk("ld_stall_sat_final", stall_cnt2, satf(expStall));
    endtask

    initial begin
        fork
            monitor();
        join_none

        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", dmem_req_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Reset while a load waits for its response; the late response must be dropped.
        in_valid = 1; alu_out = 32'h10; dest_reg = 4'd2; reg_write = 1; mem_read = 1; mem_to_reg = 1;
        dmem_req_ready = 1;
        @(negedge clk);
        clearIn();
        chk("rl_req_valid", dmem_req_valid, 1);
        chk("rl_in_ready", in_ready, 0);
        @(negedge clk);
        dmem_req_ready = 0;
        chk("rl_req_drop", dmem_req_valid, 0);
        chk("rl_in_wait", in_ready, 0);
        rst_n = 0;
        #1;
        chk("rl_rst_in_ready", in_ready, 1);
        chk("rl_rst_req_valid", dmem_req_valid, 0);
        chk("rl_rst_addr", dmem_addr, 0);
        chk("rl_rst_wb_valid", wb_valid, 0);
        chk("rl_rst_stall", stall_cnt, 0);
        chk("rl_rst_stall_sat", stall_cnt2, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        dmem_rsp_valid = 1; dmem_rdata = 32'hBAD;
        @(negedge clk);
        dmem_rsp_valid = 0;
        chk("rl_late_rsp_wb", wb_valid, 0);
        chk("rl_late_rsp_ready", in_ready, 1);
        expStall = 0;

        // Back-to-back ALU ops.
        sendOp(32'd5, 32'h0, 4'd3, 1, 0, 0, 0, 1, 0, 32'h0);
        sendOp(32'd6, 32'h0, 4'd3, 1, 0, 0, 0, 1, 0, 32'h0);
        sendOp(32'd7, 32'h0, 4'd3, 1, 0, 0, 0, 1, 0, 32'h0);
        // Branch/jump resolution.
        sendOp(32'h0,   32'h40, 4'd0, 0, 1, 0, 1, 0, 1, 32'h40);
        sendOp(32'h4,   32'h80, 4'd0, 0, 1, 0, 0, 0, 0, 32'h0);
        sendOp(32'h100, 32'h40, 4'd1, 1, 1, 1, 0, 1, 1, 32'h100);
        sendOp(32'h200, 32'h60, 4'd0, 1, 0, 1, 1, 0, 0, 32'h0);
        clearIn();
        @(negedge clk);
        chk("alu_stall_none", stall_cnt, 0);

        doStore(32'h20, 32'hDEADBEEF, 0, 2);
        doStore(32'h24, 32'hCAFEF00D, 1, 0);

        doLoad(32'h10, 4'd0, 1, 32'h1234, 0, 2, 0, 32'h1234);
        doLoad(32'h10, 4'd2, 1, 32'h1234, 0, 2, 1, 32'h1234);
        doLoad(32'h14, 4'd5, 0, 32'hAAAA, 0, 0, 1, 32'h14);

        // Saturation of the 2-bit counter instance under a long request stall.
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        expStall = 0;
        @(negedge clk);
        doLoad(32'h30, 4'd7, 1, 32'h5555, 6, 1, 1, 32'h5555);

        repeat (3) @(negedge clk);
        chk("wb_queue_drained", wbQ.size(), 0);
        chk("redirect_queue_drained", rdQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
